// File: rtl/geofence_poly_if.sv
// Sample/result bundle between coordinate capture and the polygon geofence.
// master drives samples and observes results; slave is the geofence side.
interface geofence_poly_if #(
  parameter int unsigned COORD_W = 10
);
  logic               in_valid;
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic               busy;
  logic               valid;
  logic               is_inside;
  logic               on_edge;

  modport master (
    output in_valid, X, Y,
    input  busy, valid, is_inside, on_edge
  );

  modport slave (
    input  in_valid, X, Y,
    output busy, valid, is_inside, on_edge
  );
endinterface

// File: rtl/geofence_poly.sv
// Convex-polygon geofence: collects a target plus NUM_PTS vertices, angle-sorts the
// vertices around P0 with one shared cross-product unit, then tests every edge.
module geofence_poly #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned NUM_PTS     = 6,
  parameter bit          EDGE_INSIDE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  geofence_poly_if.slave bus
);

  localparam int unsigned DW   = COORD_W + 1;
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned IW   = $clog2(NUM_PTS);
  localparam int unsigned CNTW = $clog2(NUM_PTS + 1);

  localparam logic [CNTW-1:0] LAST_CNT  = CNTW'(NUM_PTS);
  localparam logic [IW-1:0]   LAST_PAIR = IW'(NUM_PTS - 2);
  localparam logic [IW-1:0]   LAST_PASS = IW'(NUM_PTS - 3);
  localparam logic [IW-1:0]   LAST_K    = IW'(NUM_PTS - 1);

  typedef enum logic [1:0] {COLLECT, SORT, TEST, DONE} state_e;

  state_e             state_q;
  logic [CNTW-1:0]    cnt_q;
  logic [IW-1:0]      pass_q;
  logic [IW-1:0]      pair_q;
  logic [CNTW-1:0]    k_q;
  logic [COORD_W-1:0] px_q [NUM_PTS];
  logic [COORD_W-1:0] py_q [NUM_PTS];
  logic [COORD_W-1:0] tx_q;
  logic [COORD_W-1:0] ty_q;
  logic               epos_q;
  logic               ezero_q;
  logic               any_pos_q;
  logic               any_zero_q;
  logic               busy_q;
  logic               valid_q;
  logic               inside_q;
  logic               edge_q;

  logic [IW-1:0]        ia_c;
  logic [IW-1:0]        ib_c;
  logic [IW-1:0]        kk_c;
  logic [IW-1:0]        wr_idx_c;
  logic [COORD_W-1:0]   ox_c, oy_c, ax_c, ay_c, bx_c, by_c;
  logic signed [DW-1:0] dax_c, day_c, dbx_c, dby_c;
  logic signed [PW-1:0] p1_c, p2_c;
  logic signed [CW-1:0] cross_c;
  logic                 pos_c;
  logic                 zero_c;
  logic                 fin_pos_c;
  logic                 fin_zero_c;

  // Shared cross-product operand select: P0-anchored pairs in SORT, target-anchored edges in TEST
  always_comb begin
    kk_c = '0;
    ia_c = '0;
    ib_c = '0;
    ox_c = tx_q;
    oy_c = ty_q;
    if (k_q < LAST_CNT) kk_c = IW'(k_q);
    if (state_q == SORT) begin
      ia_c = pair_q;
      ib_c = pair_q + IW'(1);
      ox_c = px_q[0];
      oy_c = py_q[0];
    end else begin
      ia_c = kk_c;
      ib_c = (kk_c == LAST_K) ? '0 : kk_c + IW'(1);
    end
  end

  assign ax_c = px_q[ia_c];
  assign ay_c = py_q[ia_c];
  assign bx_c = px_q[ib_c];
  assign by_c = py_q[ib_c];

  // Zero-extended operands keep full-scale differences exact in DW signed bits
  assign dax_c   = $signed({1'b0, ax_c}) - $signed({1'b0, ox_c});
  assign day_c   = $signed({1'b0, ay_c}) - $signed({1'b0, oy_c});
  assign dbx_c   = $signed({1'b0, bx_c}) - $signed({1'b0, ox_c});
  assign dby_c   = $signed({1'b0, by_c}) - $signed({1'b0, oy_c});
  assign p1_c    = PW'(dax_c) * PW'(dby_c);
  assign p2_c    = PW'(day_c) * PW'(dbx_c);
  assign cross_c = CW'(p1_c) - CW'(p2_c);
  assign zero_c  = (cross_c == '0);
  assign pos_c   = !cross_c[CW-1] && !zero_c;

  assign wr_idx_c   = IW'(cnt_q - CNTW'(1));
  assign fin_pos_c  = any_pos_q | epos_q;
  assign fin_zero_c = any_zero_q | ezero_q;

  // Edge signs are registered once, so TEST spends one extra cycle draining the last edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      pass_q     <= '0;
      pair_q     <= IW'(1);
      k_q        <= '0;
      epos_q     <= 1'b0;
      ezero_q    <= 1'b0;
      any_pos_q  <= 1'b0;
      any_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      inside_q   <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.in_valid) begin
            if (cnt_q == '0) begin
              tx_q <= bus.X;
              ty_q <= bus.Y;
            end else begin
              px_q[wr_idx_c] <= bus.X;
              py_q[wr_idx_c] <= bus.Y;
            end
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              pass_q  <= '0;
              pair_q  <= IW'(1);
              busy_q  <= 1'b1;
              state_q <= SORT;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end

        SORT: begin
          if (pos_c) begin
            px_q[ia_c] <= bx_c;
            py_q[ia_c] <= by_c;
            px_q[ib_c] <= ax_c;
            py_q[ib_c] <= ay_c;
          end
          if (pair_q == LAST_PAIR) begin
            pair_q <= IW'(1);
            if (pass_q == LAST_PASS) begin
              k_q        <= '0;
              any_pos_q  <= 1'b0;
              any_zero_q <= 1'b0;
              state_q    <= TEST;
            end else begin
              pass_q <= pass_q + IW'(1);
            end
          end else begin
            pair_q <= pair_q + IW'(1);
          end
        end

        TEST: begin
          if (k_q != LAST_CNT) begin
            epos_q  <= pos_c;
            ezero_q <= zero_c;
          end
          if (k_q != '0) begin
            any_pos_q  <= fin_pos_c;
            any_zero_q <= fin_zero_c;
          end
          if (k_q == LAST_CNT) begin
            valid_q <= 1'b1;
            state_q <= DONE;
            if (fin_pos_c) begin
              inside_q <= 1'b0;
              edge_q   <= 1'b0;
            end else if (fin_zero_c) begin
              inside_q <= EDGE_INSIDE;
              edge_q   <= 1'b1;
            end else begin
              inside_q <= 1'b1;
              edge_q   <= 1'b0;
            end
          end else begin
            k_q <= k_q + CNTW'(1);
          end
        end

        DONE: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= COLLECT;
        end

        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.is_inside = inside_q;
  assign bus.on_edge   = edge_q;

endmodule
